// File: rtl/cp0_exc_commit.sv
// cp0_exc_commit
// CP0 register file and exception-commit engine for the MEM1 stage.
//   - Commits the prioritised exception from the MEM-stage exception unit into
//     Status.EXL, Cause (BD/ExcCode/CE), EPC and BadVAddr.
//   - Runs the Count/Compare timer and latches the timer interrupt (TI/IP7).
//   - Synchronises the six hardware interrupt lines into Cause.IP7_2.
//   - Serves MFC0 reads (combinational) and MTC0 writes (masked per register).
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   MEM_ExcType/Stall/PC/...    commit context from the MEM-stage exception unit
//   Ext_Int                     asynchronous interrupt lines -> IP7..IP2
//   MTC0_En/CP0_Addr/MTC0_Data  CP0 write port (CP0_Addr also selects MFC0_Data)
//   MFC0_Data                   combinational read of CP0_Addr (no write bypass)
//   CP0_Status_*, CP0_Cause_*   live fields fed back to the exception unit
//   CP0_Ebase, CP0_EPC          exception base and ERET target
// Handshake: there is no valid/ready pair; every input is sampled on each rising
// edge, and MEM_Stall=1 suppresses commit, ERET and MTC0 for that edge while the
// timer and interrupt synchroniser keep running.
module cp0_exc_commit #(
  parameter int COUNT_DIV = 2  // clocks per Count increment, 1 or 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  MEM_ExcType,
  input  logic        MEM_Stall,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_IsInDelaySlot,
  input  logic [31:0] MEM_VAddr,
  input  logic [5:0]  Ext_Int,
  input  logic        MTC0_En,
  input  logic [4:0]  CP0_Addr,
  input  logic [31:0] MTC0_Data,
  output logic [31:0] MFC0_Data,
  output logic        CP0_Status_BEV,
  output logic [7:0]  CP0_Status_IM7_0,
  output logic        CP0_Status_EXL,
  output logic        CP0_Status_IE,
  output logic [5:0]  CP0_Cause_IP7_2,
  output logic [1:0]  CP0_Cause_IP1_0,
  output logic [31:0] CP0_Ebase,
  output logic [31:0] CP0_EPC
);

  // Exception codes shared with the MEM-stage exception unit.
  localparam logic [4:0] EX_None                = 5'd0;
  localparam logic [4:0] EX_Interrupt           = 5'd1;
  localparam logic [4:0] EX_WrongAddressinIF    = 5'd2;
  localparam logic [4:0] EX_TLBRefillinIF       = 5'd3;
  localparam logic [4:0] EX_TLBInvalidinIF      = 5'd4;
  localparam logic [4:0] EX_ReservedInstruction = 5'd5;
  localparam logic [4:0] EX_CpU                 = 5'd6;
  localparam logic [4:0] EX_Syscall             = 5'd7;
  localparam logic [4:0] EX_Break               = 5'd8;
  localparam logic [4:0] EX_Overflow            = 5'd9;
  localparam logic [4:0] EX_Trap                = 5'd10;
  localparam logic [4:0] EX_Eret                = 5'd11;
  localparam logic [4:0] EX_Refetch             = 5'd12;
  localparam logic [4:0] EX_RdWrongAddressinMEM = 5'd13;
  localparam logic [4:0] EX_WrWrongAddressinMEM = 5'd14;
  localparam logic [4:0] EX_RdTLBRefillinMEM    = 5'd15;
  localparam logic [4:0] EX_RdTLBInvalidinMEM   = 5'd16;
  localparam logic [4:0] EX_WrTLBRefillinMEM    = 5'd17;
  localparam logic [4:0] EX_WrTLBInvalidinMEM   = 5'd18;
  localparam logic [4:0] EX_TLBModified         = 5'd19;

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_EBASE    = 5'd15;

  logic [31:0] badvaddr, count, compare, epc;
  logic [7:0]  im;
  logic        exl, ie;
  logic        bd, ti;
  logic [1:0]  ip1_0;
  logic [4:0]  exc_code;
  logic [17:0] ebase_mid;  // EBase[29:12]; [31:30] are fixed at 2'b10
  logic [5:0]  sync1, sync2;
  logic        div_phase;

  logic        commit, eret_fire, do_mtc0, wr_count, wr_compare, count_tick;
  logic [4:0]  commit_code;
  logic        bad_from_pc, bad_from_va;
  logic [5:0]  ip7_2;

  // Exception commit beats ERET, which beats MTC0; a losing MTC0 is dropped.
  assign commit     = !MEM_Stall && (MEM_ExcType != EX_None) &&
                      (MEM_ExcType != EX_Refetch) && (MEM_ExcType != EX_Eret);
  assign eret_fire  = !MEM_Stall && (MEM_ExcType == EX_Eret);
  assign do_mtc0    = MTC0_En && !MEM_Stall && !commit && !eret_fire;
  assign wr_count   = do_mtc0 && (CP0_Addr == A_COUNT);
  assign wr_compare = do_mtc0 && (CP0_Addr == A_COMPARE);

  // div_phase toggles every cycle; with COUNT_DIV=1 every cycle ticks.
  assign count_tick = (COUNT_DIV == 1) || div_phase;

  // TI drives IP7 directly so a match is visible one cycle after it occurs.
  assign ip7_2 = {sync2[5] | ti, sync2[4:0]};

  always_comb begin
    commit_code = 5'h0A;  // undefined codes are reported as reserved instruction
    bad_from_pc = 1'b0;
    bad_from_va = 1'b0;
    case (MEM_ExcType)
      EX_Interrupt:           commit_code = 5'h00;
      EX_TLBModified:         begin commit_code = 5'h01; bad_from_va = 1'b1; end
      EX_TLBRefillinIF,
      EX_TLBInvalidinIF:      begin commit_code = 5'h02; bad_from_pc = 1'b1; end
      EX_RdTLBRefillinMEM,
      EX_RdTLBInvalidinMEM:   begin commit_code = 5'h02; bad_from_va = 1'b1; end
      EX_WrTLBRefillinMEM,
      EX_WrTLBInvalidinMEM:   begin commit_code = 5'h03; bad_from_va = 1'b1; end
      EX_WrongAddressinIF:    begin commit_code = 5'h04; bad_from_pc = 1'b1; end
      EX_RdWrongAddressinMEM: begin commit_code = 5'h04; bad_from_va = 1'b1; end
      EX_WrWrongAddressinMEM: begin commit_code = 5'h05; bad_from_va = 1'b1; end
      EX_Syscall:             commit_code = 5'h08;
      EX_Break:               commit_code = 5'h09;
      EX_ReservedInstruction: commit_code = 5'h0A;
      EX_CpU:                 commit_code = 5'h0B;
      EX_Overflow:            commit_code = 5'h0C;
      EX_Trap:                commit_code = 5'h0D;
      default:                commit_code = 5'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr  <= 32'h0;
      count     <= 32'h0;
      compare   <= 32'h0;
      epc       <= 32'h0;
      im        <= 8'h0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      bd        <= 1'b0;
      ti        <= 1'b0;
      ip1_0     <= 2'b0;
      exc_code  <= 5'h0;
      ebase_mid <= 18'h0;
      sync1     <= 6'h0;
      sync2     <= 6'h0;
      div_phase <= 1'b0;
    end else begin
      sync1 <= Ext_Int;
      sync2 <= sync1;

      if (wr_count) begin
        count     <= MTC0_Data;
        div_phase <= 1'b0;
      end else begin
        div_phase <= ~div_phase;
        if (count_tick) count <= count + 32'd1;
      end

      // TI is sticky until software rewrites Compare.
      if (wr_compare) begin
        compare <= MTC0_Data;
        ti      <= 1'b0;
      end else if ((count == compare) && (compare != 32'h0)) begin
        ti <= 1'b1;
      end

      if (commit) begin
        exc_code <= commit_code;
        // A nested exception keeps the original EPC/BD so ERET returns to it.
        if (!exl) begin
          epc <= MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
          bd  <= MEM_IsInDelaySlot;
        end
        exl <= 1'b1;
        if (bad_from_pc)      badvaddr <= MEM_PC;
        else if (bad_from_va) badvaddr <= MEM_VAddr;
      end else if (eret_fire) begin
        exl <= 1'b0;
      end else if (do_mtc0) begin
        case (CP0_Addr)
          A_STATUS: begin
            im  <= MTC0_Data[15:8];
            exl <= MTC0_Data[1];
            ie  <= MTC0_Data[0];
          end
          A_CAUSE: ip1_0     <= MTC0_Data[9:8];
          A_EPC:   epc       <= MTC0_Data;
          A_EBASE: ebase_mid <= MTC0_Data[29:12];
          default: ;
        endcase
      end
    end
  end

  // Cause.CE is only ever written with 0 (by CpU), so it reads as constant 0.
  always_comb begin
    MFC0_Data = 32'h0;
    case (CP0_Addr)
      A_BADVADDR: MFC0_Data = badvaddr;
      A_COUNT:    MFC0_Data = count;
      A_COMPARE:  MFC0_Data = compare;
      A_STATUS:   MFC0_Data = {9'h0, 1'b1, 6'h0, im, 6'h0, exl, ie};
      A_CAUSE:    MFC0_Data = {bd, ti, 2'b00, 12'h0, ip7_2, ip1_0, 1'b0, exc_code, 2'b00};
      A_EPC:      MFC0_Data = epc;
      A_EBASE:    MFC0_Data = {2'b10, ebase_mid, 12'h0};
      default:    MFC0_Data = 32'h0;
    endcase
  end

  assign CP0_Status_BEV   = 1'b1;  // BEV resets to 1 and is not writable
  assign CP0_Status_IM7_0 = im;
  assign CP0_Status_EXL   = exl;
  assign CP0_Status_IE    = ie;
  assign CP0_Cause_IP7_2  = ip7_2;
  assign CP0_Cause_IP1_0  = ip1_0;
  assign CP0_Ebase        = {2'b10, ebase_mid, 12'h0};
  assign CP0_EPC          = epc;

endmodule

// File: tb/tb_cp0_exc_commit.sv
module tb_cp0_exc_commit;

  localparam int DIV = 2;

  localparam logic [4:0] EX_NONE = 5'd0,  EX_INT = 5'd1,   EX_ADEIF = 5'd2,  EX_TLBRIF = 5'd3;
  localparam logic [4:0] EX_TLBIIF = 5'd4, EX_RI = 5'd5,    EX_CPU = 5'd6,    EX_SYS = 5'd7;
  localparam logic [4:0] EX_BRK = 5'd8,   EX_OV = 5'd9,     EX_TRAP = 5'd10,  EX_ERET = 5'd11;
  localparam logic [4:0] EX_REF = 5'd12,  EX_ADEL = 5'd13,  EX_ADES = 5'd14,  EX_RTLBR = 5'd15;
  localparam logic [4:0] EX_RTLBI = 5'd16, EX_WTLBR = 5'd17, EX_WTLBI = 5'd18, EX_MOD = 5'd19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic [4:0]  MEM_ExcType = 5'd0;
  logic        MEM_Stall = 1'b0;
  logic [31:0] MEM_PC = 32'h0;
  logic        MEM_IsInDelaySlot = 1'b0;
  logic [31:0] MEM_VAddr = 32'h0;
  logic [5:0]  Ext_Int = 6'h0;
  logic        MTC0_En = 1'b0;
  logic [4:0]  CP0_Addr = 5'd0;
  logic [31:0] MTC0_Data = 32'h0;
  logic [31:0] MFC0_Data;
  logic        CP0_Status_BEV, CP0_Status_EXL, CP0_Status_IE;
  logic [7:0]  CP0_Status_IM7_0;
  logic [5:0]  CP0_Cause_IP7_2;
  logic [1:0]  CP0_Cause_IP1_0;
  logic [31:0] CP0_Ebase, CP0_EPC;

  cp0_exc_commit #(.COUNT_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .MEM_ExcType(MEM_ExcType), .MEM_Stall(MEM_Stall),
    .MEM_PC(MEM_PC), .MEM_IsInDelaySlot(MEM_IsInDelaySlot), .MEM_VAddr(MEM_VAddr),
    .Ext_Int(Ext_Int), .MTC0_En(MTC0_En), .CP0_Addr(CP0_Addr), .MTC0_Data(MTC0_Data),
    .MFC0_Data(MFC0_Data), .CP0_Status_BEV(CP0_Status_BEV),
    .CP0_Status_IM7_0(CP0_Status_IM7_0), .CP0_Status_EXL(CP0_Status_EXL),
    .CP0_Status_IE(CP0_Status_IE), .CP0_Cause_IP7_2(CP0_Cause_IP7_2),
    .CP0_Cause_IP1_0(CP0_Cause_IP1_0), .CP0_Ebase(CP0_Ebase), .CP0_EPC(CP0_EPC)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: Count is the last loaded value plus elapsed edges / DIV.
  logic [31:0] m_bad, m_base, m_cmp, m_epc, m_ebase;
  int unsigned m_n;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [1:0]  m_ip10;
  logic [4:0]  m_exc;
  logic [5:0]  m_hist[$];  // interrupt lines seen at the last two edges
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_n / DIV);
  endfunction

  function automatic logic [5:0] m_ip72();
    logic [5:0] s;
    s = m_hist[0];
    s[5] = s[5] | m_ti;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count();
      5'd11: return m_cmp;
      5'd12: return 32'h0040_0000 | {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13: return {m_bd, m_ti, 14'h0, m_ip72(), m_ip10, 1'b0, m_exc, 2'b00};
      5'd14: return m_epc;
      5'd15: return m_ebase;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] code_of(input logic [4:0] t);
    case (t)
      EX_INT: return 5'h00;
      EX_MOD: return 5'h01;
      EX_TLBRIF, EX_TLBIIF, EX_RTLBR, EX_RTLBI: return 5'h02;
      EX_WTLBR, EX_WTLBI: return 5'h03;
      EX_ADEIF, EX_ADEL: return 5'h04;
      EX_ADES: return 5'h05;
      EX_SYS: return 5'h08;
      EX_BRK: return 5'h09;
      EX_RI: return 5'h0A;
      EX_CPU: return 5'h0B;
      EX_OV: return 5'h0C;
      EX_TRAP: return 5'h0D;
      default: return 5'h0A;
    endcase
  endfunction

  task automatic model_edge();
    logic commit, eret, wr;
    logic [31:0] c;
    if (!resetn) begin
      m_bad = 0; m_base = 0; m_n = 0; m_cmp = 0; m_epc = 0; m_ebase = 32'h8000_0000;
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ip10 = 0; m_exc = 0;
      m_hist = '{6'h0, 6'h0};
      m_valid = 1'b1;
      return;
    end
    m_hist.push_back(Ext_Int);
    void'(m_hist.pop_front());
    commit = !MEM_Stall && !(MEM_ExcType inside {EX_NONE, EX_REF, EX_ERET});
    eret   = !MEM_Stall && MEM_ExcType == EX_ERET;
    wr     = MTC0_En && !MEM_Stall && !commit && !eret;
    c = m_count();
    if (wr && CP0_Addr == 5'd11) m_ti = 0;
    else if (c == m_cmp && m_cmp != 0) m_ti = 1;
    if (wr && CP0_Addr == 5'd9) begin m_base = MTC0_Data; m_n = 0; end
    else m_n++;
    if (commit) begin
      m_exc = code_of(MEM_ExcType);
      if (!m_exl) begin
        m_epc = MEM_IsInDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
        m_bd  = MEM_IsInDelaySlot;
      end
      m_exl = 1;
      if (MEM_ExcType inside {EX_ADEIF, EX_TLBRIF, EX_TLBIIF}) m_bad = MEM_PC;
      if (MEM_ExcType inside {EX_ADEL, EX_ADES, EX_RTLBR, EX_RTLBI, EX_WTLBR, EX_WTLBI, EX_MOD})
        m_bad = MEM_VAddr;
    end
    if (eret) m_exl = 0;
    if (wr) begin
      case (CP0_Addr)
        5'd11: m_cmp = MTC0_Data;
        5'd12: begin m_im = MTC0_Data[15:8]; m_exl = MTC0_Data[1]; m_ie = MTC0_Data[0]; end
        5'd13: m_ip10 = MTC0_Data[9:8];
        5'd14: m_epc = MTC0_Data;
        5'd15: m_ebase = {2'b10, MTC0_Data[29:12], 12'h0};
        default: ;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] mfc0, epc, ebase;
    logic [7:0]  im;
    logic        exl, ie;
    logic [5:0]  ip72;
    logic [1:0]  ip10;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mfc0", MFC0_Data, e.mfc0);
      chk("epc", CP0_EPC, e.epc);
      chk("ebase", CP0_Ebase, e.ebase);
      chk("im", {24'h0, CP0_Status_IM7_0}, {24'h0, e.im});
      chk("exl", {31'h0, CP0_Status_EXL}, {31'h0, e.exl});
      chk("ie", {31'h0, CP0_Status_IE}, {31'h0, e.ie});
      chk("bev", {31'h0, CP0_Status_BEV}, 32'h1);
      chk("ip7_2", {26'h0, CP0_Cause_IP7_2}, {26'h0, e.ip72});
      chk("ip1_0", {30'h0, CP0_Cause_IP1_0}, {30'h0, e.ip10});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rn, input logic [4:0] exc, input logic stall,
                       input logic [31:0] pc, input logic ds, input logic [31:0] va,
                       input logic [5:0] ext, input logic mtc0, input logic [4:0] addr,
                       input logic [31:0] data);
    exp_t e;
    @(posedge clk);
    #2;
    resetn = rn; MEM_ExcType = exc; MEM_Stall = stall; MEM_PC = pc;
    MEM_IsInDelaySlot = ds; MEM_VAddr = va; Ext_Int = ext; MTC0_En = mtc0;
    CP0_Addr = addr; MTC0_Data = data;
    if (m_valid) begin
      e.mfc0 = m_read(addr); e.epc = m_epc; e.ebase = m_ebase; e.im = m_im;
      e.exl = m_exl; e.ie = m_ie; e.ip72 = m_ip72(); e.ip10 = m_ip10;
      exp_q.push_back(e);
    end
    model_edge();
  endtask

  task automatic idle(input logic [4:0] addr);
    drive(1'b1, EX_NONE, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0, addr, 32'h0);
  endtask

  task automatic wr0(input logic [4:0] addr, input logic [31:0] data);
    drive(1'b1, EX_NONE, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b1, addr, data);
  endtask

  task automatic exc(input logic [4:0] t, input logic [31:0] pc, input logic ds,
                     input logic [31:0] va);
    drive(1'b1, t, 1'b0, pc, ds, va, 6'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin : stim
    logic [4:0] codes[20];
    logic [4:0] addrs[8];
    int hit;
    for (int i = 0; i < 20; i++) codes[i] = 5'(i);
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};

    // reset
    for (int i = 0; i < 3; i++)
      drive(1'b0, EX_OV, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 6'h3F, 1'b1, 5'd9, 32'h1234);
    @(negedge clk);
    chk("rst_count", MFC0_Data, 32'h0);
    idle(5'd12); @(negedge clk); chk("rst_status", MFC0_Data, 32'h0040_0000);
    idle(5'd15); @(negedge clk); chk("rst_ebase", MFC0_Data, 32'h8000_0000);
    idle(5'd13); @(negedge clk); chk("rst_cause", MFC0_Data, 32'h0);
    idle(5'd14); @(negedge clk); chk("rst_epc", MFC0_Data, 32'h0);
    idle(5'd8);  @(negedge clk); chk("rst_badvaddr", MFC0_Data, 32'h0);

    // overflow in a delay slot, then nested syscall, then eret
    exc(EX_OV, 32'hBFC0_0100, 1'b1, 32'h0);
    idle(5'd13); @(negedge clk);
    chk("ov_cause", MFC0_Data, 32'h8000_0030);
    chk("ov_epc", CP0_EPC, 32'hBFC0_00FC);
    chk("ov_exl", {31'h0, CP0_Status_EXL}, 32'h1);
    exc(EX_SYS, 32'h0000_1234, 1'b0, 32'h0);
    idle(5'd13); @(negedge clk);
    chk("sys_cause", MFC0_Data, 32'h8000_0020);
    chk("sys_epc", CP0_EPC, 32'hBFC0_00FC);
    exc(EX_ERET, 32'h0, 1'b0, 32'h0);
    idle(5'd14); @(negedge clk);
    chk("eret_exl", {31'h0, CP0_Status_EXL}, 32'h0);
    chk("eret_epc", MFC0_Data, 32'hBFC0_00FC);

    // bad address captures
    exc(EX_ADEL, 32'h0000_0100, 1'b0, 32'h8000_0003);
    idle(5'd8); @(negedge clk);  chk("adel_bad", MFC0_Data, 32'h8000_0003);
    idle(5'd13); @(negedge clk); chk("adel_cause", MFC0_Data, 32'h0000_0010);
    exc(EX_ADEIF, 32'h8000_1002, 1'b0, 32'h0);
    idle(5'd8); @(negedge clk);  chk("adeif_bad", MFC0_Data, 32'h8000_1002);
    exc(EX_ERET, 32'h0, 1'b0, 32'h0);

    // timer: Count=0 then Compare=10 -> IP7 after 21 edges from the Count load
    wr0(5'd9, 32'h0);
    wr0(5'd11, 32'd10);
    hit = 0;
    for (int k = 1; k <= 40 && hit == 0; k++) begin
      idle(5'd9); @(negedge clk);
      if (CP0_Cause_IP7_2[5]) hit = k;
    end
    chk("timer_ip7_edge", 32'(hit), 32'd21);
    wr0(5'd11, 32'd100);
    idle(5'd13); @(negedge clk);
    chk("timer_ip7_clr", {31'h0, CP0_Cause_IP7_2[5]}, 32'h0);

    // MTC0 Status in the same cycle as a committing Break is discarded
    drive(1'b1, EX_BRK, 1'b0, 32'h40, 1'b0, 32'h0, 6'h0, 1'b1, 5'd12, 32'h0000_FF01);
    idle(5'd12); @(negedge clk); chk("brk_status", MFC0_Data, 32'h0040_0002);
    idle(5'd13); @(negedge clk); chk("brk_cause", MFC0_Data, 32'h0000_0024);
    exc(EX_ERET, 32'h0, 1'b0, 32'h0);
    drive(1'b1, EX_BRK, 1'b1, 32'h80, 1'b1, 32'h0, 6'h0, 1'b1, 5'd12, 32'h0000_FF01);
    idle(5'd12); @(negedge clk); chk("stall_status", MFC0_Data, 32'h0040_0000);
    chk("stall_epc", CP0_EPC, 32'h0000_0040);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] a;
      logic [31:0] d;
      a = addrs[$urandom_range(0, 7)];
      d = $urandom;
      if (a == 5'd9 && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(0, 5));
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 2) == 0) ? codes[$urandom_range(0, 19)] : EX_NONE,
            ($urandom_range(0, 3) == 0),
            $urandom, 1'($urandom_range(0, 1)), $urandom,
            6'($urandom), ($urandom_range(0, 2) == 0), a, d);
    end
    idle(5'd0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_commit.md
# cp0_exc_commit

CP0 register file and exception-commit engine for the MEM1 stage. It consumes the prioritised exception code and PC context chosen by the MEM-stage exception unit and updates Status, Cause, EPC and BadVAddr on the commit cycle. It runs the Count/Compare timer and synchronises hardware interrupt lines. It serves MFC0 reads and MTC0 writes, and feeds the live Status, Cause and EBase fields back to the exception unit.

## Interface
- Parameters
  - `COUNT_DIV`, default 2: number of clocks per Count increment; must be 1 or 2.
- Ports
  - `clk` in 1: core clock.
  - `resetn` in 1: synchronous, active-low reset.
  - `MEM_ExcType` in 5: prioritised exception code, using the codebase `EX_*` encodings.
  - `MEM_Stall` in 1: MEM stage held; suppresses commit, MTC0 and the ERET action.
  - `MEM_PC` in 32: PC of the committing instruction.
  - `MEM_IsInDelaySlot` in 1: the committing instruction is in a branch delay slot.
  - `MEM_VAddr` in 32: data virtual address of the committing load/store.
  - `Ext_Int` in 6: asynchronous hardware interrupt lines, mapped to IP7..IP2.
  - `MTC0_En` in 1: CP0 write request.
  - `CP0_Addr` in 5: register number for both read and write (sel is always 0; EBase is reg 15).
  - `MTC0_Data` in 32: write data.
  - `MFC0_Data` out 32: combinational read of `CP0_Addr`.
  - `CP0_Status_BEV` out 1, `CP0_Status_IM7_0` out 8, `CP0_Status_EXL` out 1, `CP0_Status_IE` out 1: Status fields.
  - `CP0_Cause_IP7_2` out 6, `CP0_Cause_IP1_0` out 2: Cause pending-interrupt fields.
  - `CP0_Ebase` out 32: EBase register.
  - `CP0_EPC` out 32: EPC register, used as the ERET target.

## Operation
- Registers and reset values:
  - BadVAddr (8): 0.
  - Count (9): 0.
  - Compare (11): 0.
  - Status (12): 0x0040_0000, i.e. BEV=1.
  - Cause (13): 0.
  - EPC (14): 0.
  - EBase (15): 0x8000_0000.
  - All other addresses read 0.
- MTC0 writable masks:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP1_0[9:8].
  - EBase: [29:12].
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr: not writable.
- Commit happens when `MEM_ExcType` is neither `EX_None`, `EX_Refetch` nor `EX_Eret`, and `MEM_Stall` is 0. On commit:
  - Cause.ExcCode[6:2] is set from the table below.
  - If Status.EXL=0: EPC = `MEM_IsInDelaySlot` ? `MEM_PC`-4 : `MEM_PC`, and Cause.BD[31] = `MEM_IsInDelaySlot`.
  - If Status.EXL=1: EPC and BD are left unchanged.
  - Status.EXL is set to 1.
- ExcCode table:
  - Interrupt 0x00; TLBModified 0x01.
  - TLBRefill/Invalid in IF or read: 0x02. Write: 0x03.
  - WrongAddressinIF and RdWrongAddress: 0x04. WrWrongAddress: 0x05.
  - Syscall 0x08; Break 0x09; ReservedInstruction 0x0A; CpU 0x0B; Overflow 0x0C; Trap 0x0D.
- BadVAddr on commit:
  - WrongAddressinIF or TLB*inIF: loaded with `MEM_PC`.
  - Rd/Wr WrongAddress, Rd/Wr TLB*, TLBModified: loaded with `MEM_VAddr`.
  - Any other code: unchanged.
- CpU: Cause.CE[29:28] is written with 0.
- Eret with `MEM_Stall`=0: Status.EXL is cleared. No other register changes.
- Refetch and None: no register change.
- Priority within one cycle, highest first: exception commit, then ERET, then MTC0. When an exception commits or ERET fires, the MTC0 in that cycle is discarded.
- Timer:
  - Count increments by 1 every `COUNT_DIV` cycles and wraps from 0xFFFF_FFFF to 0.
  - When Count == Compare and Compare != 0, Cause.TI[30] and IP7 are set; they hold until the next MTC0 to Compare.
  - MTC0 to Count loads the value and restarts the divider phase.
  - MTC0 to Compare clears TI and IP7 in the same write.
- Interrupt synchroniser:
  - `Ext_Int` passes through a 2-flop synchroniser.
  - Cause.IP7_2 = sync(`Ext_Int`), with bit 5 ORed with TI.
  - IP is sampled every cycle, independent of `MEM_Stall`.

## Timing
- All register updates take effect on the rising edge after the request; the outputs reflect the new value in the next cycle.
- `MFC0_Data` is combinational from the current register state. There is no bypass from a same-cycle MTC0: the read returns the old value.
- `Ext_Int` to `CP0_Cause_IP7_2` latency is 2 cycles.
- Count == Compare match to IP7 visible: 1 cycle.
- During reset (`resetn`=0 at an edge), every register takes its reset value and all inputs are ignored. The synchroniser flops clear to 0.
- Reset asserted mid-stall or mid-commit: reset wins.

## Test plan
- Reset -> Status=0x0040_0000, EBase=0x8000_0000; all other registers read 0.
- `EX_Overflow` committed, `MEM_PC`=0xBFC0_0100, delay slot=1, EXL=0 -> next cycle EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=0x0C, EXL=1.
- Second `EX_Syscall` committed while EXL=1 -> EPC and BD unchanged, ExcCode=0x08. Then `EX_Eret` -> EXL=0, EPC unchanged.
- `EX_RdWrongAddressinMEM`, `MEM_VAddr`=0x8000_0003 -> BadVAddr=0x8000_0003, ExcCode=0x04. Then `EX_WrongAddressinIF`, `MEM_PC`=0x8000_1002 -> BadVAddr=0x8000_1002.
- MTC0 Compare=10, Count=0, `COUNT_DIV`=2 -> IP7=1 at about cycle 21. MTC0 Compare=100 -> IP7=0 the next cycle.
- Same cycle: MTC0 Status=0xFF01 plus `EX_Break` -> Status only gains EXL=1, IM is unchanged, ExcCode=0x09. With `MEM_Stall`=1 the same stimulus -> no change.
